// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if
//   Bundles the requester handshakes, per-requester results and the link to
//   the shared 4x4 multiplier used by mul_share_arbiter.
//   Signals:
//     req0/req1         level requests, held until granted
//     a0,b0 / a1,b1     4-bit unsigned operands, stable while req is high
//     gnt0/gnt1         one-cycle grant pulses
//     done0/done1       one-cycle result-valid pulses
//     res0/res1         8-bit per-requester result registers
//     mul_a/mul_b       registered operands to the shared multiplier
//     mul_res           8-bit product returned by the shared multiplier
//     busy              high while an operation is in flight
//   Modports: master = requesters + multiplier side, slave = arbiter.
interface mul_share_arbiter_if;
    logic       req0;
    logic       req1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] res0;
    logic [7:0] res1;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [7:0] mul_res;
    logic       busy;

    modport master (
        output req0, req1, a0, b0, a1, b1, mul_res,
        input  gnt0, gnt1, done0, done1, res0, res1, mul_a, mul_b, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_res,
        output gnt0, gnt1, done0, done1, res0, res1, mul_a, mul_b, busy
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one external combinational 4x4 multiplier between two requesters.
//   IDLE samples the requests, picks a winner, registers its operands onto
//   mul_a/mul_b and pulses its grant; CALC captures mul_res into the owner's
//   result register and pulses its done, then returns to IDLE.
//   Ports:
//     clk   rising-edge clock
//     rstn  asynchronous active-low reset
//     bus   mul_share_arbiter_if.slave (handshakes, results, multiplier link)
//   Build option:
//     MUL_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins contention
//                            undefined -> round-robin on a last-served pointer
module mul_share_arbiter (
    input  logic               clk,
    input  logic               rstn,
    mul_share_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic [7:0] res0_q, res0_d;
    logic [7:0] res1_q, res1_d;
    logic [3:0] mul_a_q, mul_a_d;
    logic [3:0] mul_b_q, mul_b_d;
    logic       owner_q, owner_d;
    logic       win;

`ifdef MUL_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it asks.
    always_comb begin
        win = !bus.req0;
    end
`else
    logic last_q, last_d;

    // Under contention the requester not served last wins; otherwise the
    // only active requester wins.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            win = !last_q;
        end else begin
            win = !bus.req0;
        end
    end

    // Pointer moves only when a grant is issued.
    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && (bus.req0 || bus.req1)) begin
            last_d = win;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        done_d  = '0;
        res0_d  = res0_q;
        res1_d  = res1_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    mul_a_d    = win ? bus.a1 : bus.a0;
                    mul_b_d    = win ? bus.b1 : bus.b0;
                    owner_d    = win;
                    gnt_d[win] = 1'b1;
                    state_d    = CALC;
                end
            end
            CALC: begin
                // Requests are not looked at here; they wait for IDLE.
                if (owner_q) begin
                    res1_d = bus.mul_res;
                end else begin
                    res0_d = bus.mul_res;
                end
                done_d[owner_q] = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            owner_q <= owner_d;
        end
    end

    assign bus.gnt0  = gnt_q[0];
    assign bus.gnt1  = gnt_q[1];
    assign bus.done0 = done_q[0];
    assign bus.done1 = done_q[1];
    assign bus.res0  = res0_q;
    assign bus.res1  = res1_q;
    assign bus.mul_a = mul_a_q;
    assign bus.mul_b = mul_b_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//   Bench for mul_share_arbiter: a table of single/contention operations
//   after reset, hand-written multi-cycle sequences (latency, alternation,
//   reset during CALC, short-lived request during CALC) and a randomized run
//   checked against a transaction-level reference model.
module tb_mul_share_arbiter;

    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    mul_share_arbiter_if ifc ();

    mul_share_arbiter dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc.slave)
    );

    // Shared combinational multiplier outside the arbiter.
    assign ifc.mul_res = {4'd0, ifc.mul_a} * {4'd0, ifc.mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ifc.req0 = 1'b0;
        ifc.req1 = 1'b0;
        rstn     = 1'b0;
        #2;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    typedef struct {
        bit       r0;
        bit       r1;
        bit [3:0] a0;
        bit [3:0] b0;
        bit [3:0] a1;
        bit [3:0] b1;
        int       first;
        int       res0;
        int       res1;
    } vec_t;

    vec_t vecs[7];

    // Reference model state (transaction level: grants lock out arbitration
    // for two edges, results are delivered from a queue one edge later).
    typedef struct {
        int       due;
        int       who;
        bit [7:0] val;
    } pend_t;

    pend_t    pq[$];
    int       free_at;
    int       m_last;
    bit [7:0] m_res[2];
    bit [1:0] e_gnt;
    bit [1:0] e_done;
    bit       e_busy;
    bit       r[2];
    bit [3:0] ra[2];
    bit [3:0] rb[2];

    function automatic int pick_winner(input bit q0, input bit q1, input int last);
        if (q0 && q1) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - last;
`endif
        end
        return q0 ? 0 : 1;
    endfunction

    task automatic model_edge(input int c);
        int    w;
        pend_t p;
        e_gnt  = '0;
        e_done = '0;
        if (pq.size() > 0 && pq[0].due == c) begin
            p = pq.pop_front();
            e_done[p.who] = 1'b1;
            m_res[p.who]  = p.val;
        end
        if (c >= free_at && (r[0] || r[1])) begin
            w = pick_winner(r[0], r[1], m_last);
            e_gnt[w] = 1'b1;
            free_at  = c + 2;
            m_last   = w;
            p.due    = c + 1;
            p.who    = w;
            p.val    = {4'd0, ra[w]} * {4'd0, rb[w]};
            pq.push_back(p);
        end
        e_busy = (c + 1 < free_at);
    endtask

    task automatic drive_rand();
        ifc.req0 = r[0];
        ifc.req1 = r[1];
        ifc.a0   = ra[0];
        ifc.b0   = rb[0];
        ifc.a1   = ra[1];
        ifc.b1   = rb[1];
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int first;
        do_reset();
        first    = -1;
        ifc.a0   = v.a0;
        ifc.b0   = v.b0;
        ifc.a1   = v.a1;
        ifc.b1   = v.b1;
        ifc.req0 = v.r0;
        ifc.req1 = v.r1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (first < 0 && ifc.gnt0) first = 0;
            if (first < 0 && ifc.gnt1) first = 1;
            if (ifc.gnt0) ifc.req0 = 1'b0;
            if (ifc.gnt1) ifc.req1 = 1'b0;
        end
        chk($sformatf("vec%0d_first", idx), first, v.first);
        chk($sformatf("vec%0d_res0", idx), int'(ifc.res0), v.res0);
        chk($sformatf("vec%0d_res1", idx), int'(ifc.res1), v.res1);
        chk($sformatf("vec%0d_served", idx), int'({ifc.req0, ifc.req1}), 0);
    endtask

    initial begin
        int seq[$];
        int gcount;
        tests    = 0;
        fails    = 0;
        rstn     = 1'b0;
        ifc.req0 = 1'b0;
        ifc.req1 = 1'b0;
        ifc.a0   = '0;
        ifc.b0   = '0;
        ifc.a1   = '0;
        ifc.b1   = '0;

        //          r0 r1  a0  b0  a1  b1 first res0 res1
        vecs[0] = '{1, 0,  3,  2,  0,  0, 0,   6,   0};
        vecs[1] = '{1, 0, 15, 15,  0,  0, 0, 225,   0};
        vecs[2] = '{0, 1,  0,  0,  9,  7, 1,   0,  63};
        vecs[3] = '{1, 1,  7,  4, 15,  8, 0,  28, 120};
        vecs[4] = '{1, 1, 15, 15,  1,  1, 0, 225,   1};
        vecs[5] = '{0, 1,  0,  0, 15, 15, 1,   0, 225};
        vecs[6] = '{1, 1,  0,  0, 13, 11, 0,   0, 143};

        // Reset values
        #2;
        chk("rst_gnt", int'({ifc.gnt0, ifc.gnt1}), 0);
        chk("rst_done", int'({ifc.done0, ifc.done1}), 0);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_res", int'({ifc.res0, ifc.res1}), 0);
        chk("rst_mul", int'({ifc.mul_a, ifc.mul_b}), 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Latency and busy for a single request (3x2)
        do_reset();
        ifc.a0 = 4'd3; ifc.b0 = 4'd2; ifc.req0 = 1'b1;
        step();
        chk("lat_gnt0", int'(ifc.gnt0), 1);
        chk("lat_busy_calc", int'(ifc.busy), 1);
        chk("lat_done_early", int'(ifc.done0), 0);
        chk("lat_mul", int'({ifc.mul_a, ifc.mul_b}), 8'h32);
        ifc.req0 = 1'b0;
        step();
        chk("lat_done0", int'(ifc.done0), 1);
        chk("lat_res0", int'(ifc.res0), 6);
        chk("lat_gnt_off", int'(ifc.gnt0), 0);
        chk("lat_busy_idle", int'(ifc.busy), 0);
        step();
        chk("lat_done_pulse", int'(ifc.done0), 0);

        // Both requests held continuously
        do_reset();
        ifc.a0 = 4'd2; ifc.b0 = 4'd5; ifc.a1 = 4'd3; ifc.b1 = 4'd4;
        ifc.req0 = 1'b1; ifc.req1 = 1'b1;
        seq.delete();
        for (int c = 0; c < 8; c++) begin
            step();
            if (ifc.gnt0 && ifc.gnt1) chk("alt_excl", 1, 0);
            if (ifc.gnt0) seq.push_back(0);
            if (ifc.gnt1) seq.push_back(1);
        end
        gcount = seq.size();
        chk("alt_count", gcount, 4);
        for (int i = 0; i < 4 && i < gcount; i++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            chk($sformatf("alt_g%0d", i), seq[i], 0);
`else
            chk($sformatf("alt_g%0d", i), seq[i], i % 2);
`endif
        end
        ifc.req0 = 1'b0; ifc.req1 = 1'b0;

        // Reset during CALC aborts the operation
        do_reset();
        ifc.a0 = 4'd5; ifc.b0 = 4'd3; ifc.req0 = 1'b1;
        step();
        ifc.req0 = 1'b0;
        step();
        chk("abort_pre_res0", int'(ifc.res0), 15);
        ifc.a1 = 4'd2; ifc.b1 = 4'd2; ifc.req1 = 1'b1;
        step();
        chk("abort_gnt1", int'(ifc.gnt1), 1);
        #2 rstn = 1'b0;
        #1;
        chk("abort_gnt", int'({ifc.gnt0, ifc.gnt1}), 0);
        chk("abort_busy", int'(ifc.busy), 0);
        chk("abort_res", int'({ifc.res0, ifc.res1}), 0);
        chk("abort_mul", int'({ifc.mul_a, ifc.mul_b}), 0);
        ifc.req1 = 1'b0;
        step();
        chk("abort_done_rst", int'({ifc.done0, ifc.done1}), 0);
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("abort_no_done", int'({ifc.done0, ifc.done1}), 0);
        end
        ifc.a0 = 4'd4; ifc.b0 = 4'd4; ifc.req0 = 1'b1;
        step();
        chk("abort_regrant", int'(ifc.gnt0), 1);
        ifc.req0 = 1'b0;
        step();
        chk("abort_redone", int'(ifc.done0), 1);
        chk("abort_reres", int'(ifc.res0), 16);

        // req1 pulsed during a requester-0 CALC is ignored
        do_reset();
        ifc.a0 = 4'd2; ifc.b0 = 4'd3; ifc.req0 = 1'b1;
        step();
        ifc.req0 = 1'b0;
        ifc.a1 = 4'd9; ifc.b1 = 4'd9; ifc.req1 = 1'b1;
        #3 ifc.req1 = 1'b0;
        step();
        chk("blip_done0", int'(ifc.done0), 1);
        chk("blip_res0", int'(ifc.res0), 6);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("blip_no_1", int'({ifc.gnt1, ifc.done1}), 0);
        end
        chk("blip_res1", int'(ifc.res1), 0);

        // Randomized traffic against the reference model
        do_reset();
        pq.delete();
        free_at = 0;
        m_last  = 1;
        m_res[0] = '0;
        m_res[1] = '0;
        for (int i = 0; i < 2; i++) begin
            r[i]  = 1'b0;
            ra[i] = '0;
            rb[i] = '0;
        end
        drive_rand();
        for (int c = 0; c < 400; c++) begin
            step();
            model_edge(c);
            chk($sformatf("rnd%0d_gnt", c), int'({ifc.gnt1, ifc.gnt0}), int'(e_gnt));
            chk($sformatf("rnd%0d_done", c), int'({ifc.done1, ifc.done0}), int'(e_done));
            chk($sformatf("rnd%0d_res0", c), int'(ifc.res0), int'(m_res[0]));
            chk($sformatf("rnd%0d_res1", c), int'(ifc.res1), int'(m_res[1]));
            chk($sformatf("rnd%0d_busy", c), int'(ifc.busy), int'(e_busy));
            for (int i = 0; i < 2; i++) begin
                if (r[i] && e_gnt[i]) begin
                    r[i] = 1'b0;
                end else if (!r[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        r[i]  = 1'b1;
                        ra[i] = 4'($urandom_range(15, 0));
                        rb[i] = 4'($urandom_range(15, 0));
                    end
                end else if ($urandom_range(7, 0) == 0) begin
                    r[i] = 1'b0;
                end
            end
            drive_rand();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
